mat_vec_stream: RTL and testbench



---
 rtl/mat_vec_pkg.sv | 35 +++
 rtl/mat_vec_mac.sv | 25 ++
 rtl/mat_vec_stream.sv | 103 ++++++++++
 tb/tb_mat_vec_stream.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mat_vec_pkg.sv
// mat_vec_pkg: state encoding and fixed-point helpers for mat_vec_stream (MAT_VEC_SAT_EN selects saturating output)
package mat_vec_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;
    localparam int ACC_MAX = 136;
    localparam int VAL_MAX = 64;
    typedef struct packed {
        logic ovf;
        logic [VAL_MAX-1:0] val;
    } fmt_t;
    function automatic int acc_width(input int width, input int dim);
        return 2 * width + $clog2(dim);
    endfunction
    function automatic fmt_t fmt_result(input logic signed [ACC_MAX-1:0] acc, input int frac, input int width);
        logic signed [ACC_MAX-1:0] sh;
        fmt_t f;
        sh = acc >>> frac;
        f.ovf = 1'b0;
`ifdef MAT_VEC_SAT_EN
        begin
            logic signed [ACC_MAX-1:0] hi, lo;
            hi = (ACC_MAX'(1) <<< (width - 1)) - ACC_MAX'(1);
            lo = ~hi;
            if (sh > hi) begin
                sh = hi;
                f.ovf = 1'b1;
            end else if (sh < lo) begin
                sh = lo;
                f.ovf = 1'b1;
            end
        end
`endif
        f.val = VAL_MAX'(sh) & ~({VAL_MAX{1'b1}} << width);
        return f;
    endfunction
endpackage

// File: rtl/mat_vec_mac.sv
// mat_vec_mac: signed multiply-accumulate; acc_sum is the running sum including the current product
module mat_vec_mac #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 66
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    clear,
    input  logic                    last,
    output logic signed [ACC_W-1:0] acc_sum
);
    logic signed [ACC_W-1:0] acc;
    logic signed [2*WIDTH-1:0] prod;
    assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    assign acc_sum = acc + ACC_W'(prod);
    // Accumulate one product per cycle; restart on clear and after the last column of a row
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || clear || last)
            acc <= '0;
        else
            acc <= acc_sum;
    end
endmodule

// File: rtl/mat_vec_stream.sv
// mat_vec_stream: streaming DIMxDIM fixed-point matrix x vector engine; define MAT_VEC_SAT_EN for saturating output
module mat_vec_stream
    import mat_vec_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [DIM*DIM*WIDTH-1:0]   mat_in,
    input  logic                       mat_load_in,
    output logic                       mat_ready_out,
    input  logic [DIM*WIDTH-1:0]       vec_in,
    input  logic                       vec_valid_in,
    output logic                       vec_ready_out,
    output logic [DIM*WIDTH-1:0]       vec_out,
    output logic                       vec_valid_out,
    input  logic                       vec_ready_in,
    output logic                       overflow_out
);
    localparam int ACC_W = acc_width(WIDTH, DIM);
    localparam int CW = $clog2(DIM);
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);
    state_t state;
    logic signed [WIDTH-1:0] m [DIM][DIM];
    logic signed [WIDTH-1:0] v [DIM];
    logic signed [WIDTH-1:0] res [DIM];
    logic [CW-1:0] r, c;
    logic signed [ACC_W-1:0] acc_sum;
    fmt_t f;
    logic idle, accept, row_done, unused_fmt;
    assign idle = rst_n_in && state == IDLE;
    assign mat_ready_out = idle;
    assign vec_ready_out = idle;
    assign accept = idle && vec_valid_in;
    assign row_done = state == MAC && c == LAST;
    assign f = fmt_result(ACC_MAX'(acc_sum), FRAC, WIDTH);
    assign unused_fmt = ^f;
    mat_vec_mac #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_mac (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .a        (m[r][c]),
        .b        (v[c]),
        .clear    (state != MAC),
        .last     (row_done),
        .acc_sum  (acc_sum)
    );
    genvar i;
    for (i = 0; i < DIM; i++) begin : g_out
        assign vec_out[i*WIDTH +: WIDTH] = res[i];
    end
    // FSM, row/column counters, operand registers and result registers
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            r <= '0;
            c <= '0;
            vec_valid_out <= 1'b0;
            for (int k = 0; k < DIM; k++) begin
                v[k] <= '0;
                res[k] <= '0;
                for (int j = 0; j < DIM; j++) m[k][j] <= '0;
            end
        end else begin
            if (idle && mat_load_in)
                for (int k = 0; k < DIM; k++)
                    for (int j = 0; j < DIM; j++) m[k][j] <= mat_in[(k*DIM+j)*WIDTH +: WIDTH];
            if (accept) begin
                for (int k = 0; k < DIM; k++) v[k] <= vec_in[k*WIDTH +: WIDTH];
                r <= '0;
                c <= '0;
                state <= MAC;
            end
            if (state == MAC) begin
                c <= row_done ? '0 : c + CW'(1);
                if (row_done) begin
                    res[r] <= f.val[WIDTH-1:0];
                    r <= (r == LAST) ? '0 : r + CW'(1);
                    if (r == LAST) begin
                        state <= OUT;
                        vec_valid_out <= 1'b1;
                    end
                end
            end
            if (state == OUT && vec_ready_in) begin
                state <= IDLE;
                vec_valid_out <= 1'b0;
            end
        end
    end
`ifdef MAT_VEC_SAT_EN
    // Sticky clamp flag for the vector in flight, cleared when a new vector is accepted
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || accept)
            overflow_out <= 1'b0;
        else if (row_done && f.ovf)
            overflow_out <= 1'b1;
    end
`else
    assign overflow_out = 1'b0;
`endif
endmodule

// File: tb/tb_mat_vec_stream.sv
// tb_mat_vec_stream: directed checks of mat_vec_stream for DIM=4, WIDTH=32, FRAC=16
module tb_mat_vec_stream;
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    logic [511:0] mat_in;
    logic mat_load_in, mat_ready_out;
    logic [127:0] vec_in, vec_out;
    logic vec_valid_in, vec_ready_out, vec_valid_out, vec_ready_in, overflow_out;
    int errors = 0;
    int checks = 0;
    int n;
    logic seen;

    mat_vec_stream dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .mat_in        (mat_in),
        .mat_load_in   (mat_load_in),
        .mat_ready_out (mat_ready_out),
        .vec_in        (vec_in),
        .vec_valid_in  (vec_valid_in),
        .vec_ready_out (vec_ready_out),
        .vec_out       (vec_out),
        .vec_valid_out (vec_valid_out),
        .vec_ready_in  (vec_ready_in),
        .overflow_out  (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [511:0] diag(input logic [31:0] d);
        logic [511:0] x = '0;
        for (int k = 0; k < 4; k++) x[k*5*32 +: 32] = d;
        return x;
    endfunction

    function automatic logic [511:0] fill(input logic [31:0] d);
        logic [511:0] x;
        for (int k = 0; k < 16; k++) x[k*32 +: 32] = d;
        return x;
    endfunction

    function automatic logic [127:0] pack(input logic [31:0] e0, input logic [31:0] e1,
                                          input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!vec_valid_out && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    task automatic load(input logic [511:0] mm);
        mat_in = mm;
        mat_load_in = 1'b1;
        step();
        mat_load_in = 1'b0;
    endtask

    task automatic send(input logic [127:0] vv, input string tag);
        check({tag, "_ready"}, vec_ready_out, 1'b1);
        vec_in = vv;
        vec_valid_in = 1'b1;
        step();
        vec_valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_in = '0;
        mat_load_in = 1'b0;
        vec_in = '0;
        vec_valid_in = 1'b0;
        vec_ready_in = 1'b1;
        step();
        step();
        check("rst_readys", {mat_ready_out, vec_ready_out}, 2'b00);
        check("rst_valid", vec_valid_out, 1'b0);
        check("rst_vec_out", vec_out, '0);
        check("rst_ovf", overflow_out, 1'b0);
        rst_n_in = 1'b1;
        #1;
        check("idle_mat_ready", mat_ready_out, 1'b1);

        load(diag(32'h0001_0000));
        send(pack(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000), "id");
        check("id_busy", vec_ready_out, 1'b0);
        wait_valid(n);
        check("id_latency", n, 16);
        check("id_out", vec_out, pack(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000));
        check("id_ovf", overflow_out, 1'b0);
        step();
        check("id_hs_valid", vec_valid_out, 1'b0);
        check("id_hs_ready", vec_ready_out, 1'b1);

        mat_in = diag(32'h0002_0000);
        mat_load_in = 1'b1;
        vec_in = pack(32'hFFFE_8000, 32'h0, 32'h0, 32'h0000_8000);
        vec_valid_in = 1'b1;
        step();
        mat_load_in = 1'b0;
        vec_valid_in = 1'b0;
        wait_valid(n);
        check("same_edge_latency", n, 16);
        check("same_edge_out", vec_out, pack(32'hFFFD_0000, 32'h0, 32'h0, 32'h0001_0000));
        step();

        load(diag(32'h0001_0000));
        vec_ready_in = 1'b0;
        send(pack(32'h0005_0000, 32'hFFFF_0000, 32'h0000_4000, 32'h0010_0000), "bp");
        wait_valid(n);
        check("bp_latency", n, 16);
        vec_in = pack(32'h0007_0000, 32'h0008_0000, 32'h0009_0000, 32'h000A_0000);
        vec_valid_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_valid", vec_valid_out, 1'b1);
            check("bp_hold_out", vec_out, pack(32'h0005_0000, 32'hFFFF_0000, 32'h0000_4000, 32'h0010_0000));
            check("bp_hold_ready", vec_ready_out, 1'b0);
        end
        vec_ready_in = 1'b1;
        step();
        check("bp_hs_valid", vec_valid_out, 1'b0);
        check("bp_hs_ready", vec_ready_out, 1'b1);
        step();
        vec_valid_in = 1'b0;
        wait_valid(n);
        check("bp_second_latency", n, 16);
        check("bp_second_out", vec_out, pack(32'h0007_0000, 32'h0008_0000, 32'h0009_0000, 32'h000A_0000));
        step();

        load(fill(32'h7FFF_0000));
        send({4{32'h7FFF_0000}}, "big");
        wait_valid(n);
        check("big_latency", n, 16);
`ifdef MAT_VEC_SAT_EN
        check("big_out", vec_out, {4{32'h7FFF_FFFF}});
        check("big_ovf", overflow_out, 1'b1);
`else
        check("big_out", vec_out, {4{32'h0004_0000}});
        check("big_ovf", overflow_out, 1'b0);
`endif
        step();

        load(diag(32'h0001_0000));
        send(pack(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000), "rst");
        for (int k = 0; k < 4; k++) step();
        rst_n_in = 1'b0;
        #1;
        check("rst_mid_readys", {mat_ready_out, vec_ready_out}, 2'b00);
        step();
        rst_n_in = 1'b1;
        #1;
        check("rst_mid_valid", vec_valid_out, 1'b0);
        check("rst_mid_out", vec_out, '0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            seen = seen | vec_valid_out;
        end
        check("rst_no_result", seen, 1'b0);
        send(pack(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000), "rst_after");
        wait_valid(n);
        check("rst_after_latency", n, 16);
        check("rst_after_out", vec_out, '0);
        step();

        load(diag(32'h0001_0000));
        send(pack(32'h0003_0000, 32'h0001_8000, 32'hFFFC_0000, 32'h0002_0000), "ign");
        for (int k = 0; k < 3; k++) step();
        mat_in = diag(32'h0002_0000);
        mat_load_in = 1'b1;
        step();
        mat_load_in = 1'b0;
        wait_valid(n);
        check("ign_latency", n, 12);
        check("ign_out", vec_out, pack(32'h0003_0000, 32'h0001_8000, 32'hFFFC_0000, 32'h0002_0000));
        step();
        send(pack(32'h0006_0000, 32'h0, 32'h0001_0000, 32'hFFFF_8000), "ign_next");
        wait_valid(n);
        check("ign_next_out", vec_out, pack(32'h0006_0000, 32'h0, 32'h0001_0000, 32'hFFFF_8000));
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
